// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_pkg
// Brief    : Shared types and helpers for the fetch hazard controller:
//            controller state encoding, halt opcode and BHT counter encodings.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REDIR  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_t;

    // Opcode the decoder maps onto id_is_halt
    localparam logic [3:0] OPC_HALT = 4'hF;

    // Two-bit branch history counter encodings
    localparam logic [1:0] BHT_SNT = 2'd0;
    localparam logic [1:0] BHT_WNT = 2'd1;
    localparam logic [1:0] BHT_WT  = 2'd2;
    localparam logic [1:0] BHT_ST  = 2'd3;

    // Saturating step of a history counter: up on taken, down on not-taken
    function automatic logic [1:0] bht_sat_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == BHT_ST) ? BHT_ST : ctr + 2'd1;
        end
        return (ctr == BHT_SNT) ? BHT_SNT : ctr - 2'd1;
    endfunction

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_hazard_ctrl_bht.sv
`default_nettype none
// ============================================================================
// Module   : bht_2bit
// Brief    : Array of 2-bit saturating branch history counters. Combinational
//            read port for the decode stage, synchronous update port for the
//            execute stage. A same-cycle read of the entry being updated
//            returns the value from before the update.
// Revision : 1.0 - initial release
// ============================================================================
module bht_2bit
    import fetch_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    logic [1:0] r_ctr [2**IDX_W];

    assign o_rd_ctr = r_ctr[i_rd_idx];

    // Counters start weakly not-taken; resolved branches step their entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**IDX_W; i++) begin
                r_ctr[i] <= BHT_WNT;
            end
        end else if (i_upd_en) begin
            r_ctr[i_upd_idx] <= bht_sat_step(r_ctr[i_upd_idx], i_upd_taken);
        end
    end

endmodule : bht_2bit
`default_nettype wire

// File: rtl/fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_hazard_ctrl
// Brief    : Pipeline sequencer for the fetch stage. Resolves mispredict
//            recovery, load-use interlock, halt drain and BHT-based
//            prediction into same-cycle fetch controls.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_hazard_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int REG_W     = 4,
    parameter int BHT_IDX_W = 4,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [PC_W-1:0]  id_pc,
    input  logic             id_is_branch,
    input  logic [PC_W-1:0]  id_target,
    input  logic             id_is_halt,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic             ex_predicted,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [PC_W-1:0]  ex_target,
    output logic             stall,
    output logic             flush,
    output logic             PC_sel,
    output logic             predict_taken,
    output logic [PC_W-1:0]  branch_target,
    output logic             id_ex_bubble,
    output logic             id_pred,
    output logic             halt,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] branch_cnt
);

    localparam int              DCNT_W       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCNT_W-1:0] c_drain_load = DCNT_W'(DRAIN_CYC - 1);

    ctrl_state_t       r_state;
    logic [DCNT_W-1:0] r_drain_cnt;
    logic              r_halt;
    logic [CNT_W-1:0]  r_mp_cnt;
    logic [CNT_W-1:0]  r_br_cnt;

    logic [1:0]        w_bht_ctr;
    logic              w_bht_taken;
    logic              w_resolve;
    logic              w_mispredict;
    logic              w_load_use;
    logic              w_halt_dec;
    logic              w_predict;
    logic [PC_W-1:0]   w_ex_pc_inc;
    logic              w_unused_pc_bits;

    bht_2bit #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk         (clk),
        .reset       (reset),
        .i_rd_idx    (id_pc[BHT_IDX_W-1:0]),
        .o_rd_ctr    (w_bht_ctr),
        .i_upd_en    (w_resolve),
        .i_upd_idx   (ex_pc[BHT_IDX_W-1:0]),
        .i_upd_taken (ex_taken)
    );

    // Only the low PC bits index the table
    assign w_unused_pc_bits = ^id_pc[PC_W-1:BHT_IDX_W];

    assign w_bht_taken  = (w_bht_ctr >= BHT_WT);
    assign w_resolve    = ex_valid & ex_is_branch;
    assign w_mispredict = w_resolve & (ex_taken != ex_predicted);
    assign w_load_use   = id_valid & ex_valid & ex_is_load &
                          ((id_use_rs1 & (id_rs1 == ex_rd)) |
                           (id_use_rs2 & (id_rs2 == ex_rd)));
    assign w_halt_dec   = id_valid & id_is_halt;
    assign w_predict    = id_valid & id_is_branch & w_bht_taken;
    assign w_ex_pc_inc  = ex_pc + PC_W'(1);

    assign halt           = r_halt;
    assign mispredict_cnt = r_mp_cnt;
    assign branch_cnt     = r_br_cnt;

    // Same-cycle fetch controls, prioritised mispredict > load-use > halt > predict
    always_comb begin
        stall         = 1'b0;
        flush         = 1'b0;
        PC_sel        = 1'b0;
        predict_taken = 1'b0;
        branch_target = '0;
        id_ex_bubble  = 1'b0;
        id_pred       = 1'b0;
        if (!reset) begin
            id_pred = id_is_branch & w_bht_taken;
            if (r_state != ST_HALTED) begin
                if (w_mispredict) begin
                    PC_sel        = 1'b1;
                    flush         = 1'b1;
                    id_ex_bubble  = 1'b1;
                    branch_target = ex_taken ? ex_target : w_ex_pc_inc;
                end else begin
                    case (r_state)
                        ST_RUN: begin
                            if (w_load_use) begin
                                stall        = 1'b1;
                                id_ex_bubble = 1'b1;
                            end else if (!w_halt_dec && w_predict) begin
                                predict_taken = 1'b1;
                                flush         = 1'b1;
                                branch_target = id_target;
                            end
                        end
                        ST_REDIR: begin
                            flush        = 1'b1;
                            id_ex_bubble = 1'b1;
                        end
                        ST_DRAIN: begin
                            stall = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Sequencing state, drain countdown, halt flag and saturating counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_halt      <= 1'b0;
            r_mp_cnt    <= '0;
            r_br_cnt    <= '0;
        end else begin
            if (w_resolve && !(&r_br_cnt)) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_mispredict && !(&r_mp_cnt)) begin
                r_mp_cnt <= r_mp_cnt + CNT_W'(1);
            end
            if (r_state != ST_HALTED) begin
                if (w_mispredict) begin
                    // A mispredict also cancels any wrong-path halt drain
                    r_state     <= ST_REDIR;
                    r_drain_cnt <= '0;
                end else begin
                    case (r_state)
                        ST_RUN: begin
                            if (!w_load_use && w_halt_dec) begin
                                r_state     <= ST_DRAIN;
                                r_drain_cnt <= c_drain_load;
                            end
                        end
                        ST_REDIR: begin
                            r_state <= ST_RUN;
                        end
                        ST_DRAIN: begin
                            if (r_drain_cnt == '0) begin
                                r_state <= ST_HALTED;
                                r_halt  <= 1'b1;
                            end else begin
                                r_drain_cnt <= r_drain_cnt - DCNT_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule : fetch_hazard_ctrl
`default_nettype wire

// File: tb/tb_fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_hazard_ctrl
// Brief    : Self-checking bench for fetch_hazard_ctrl: directed vector table
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_hazard_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int PC_W      = 8;
    localparam int REG_W     = 4;
    localparam int BHT_IDX_W = 4;
    localparam int DRAIN_CYC = 3;
    localparam int CNT_W     = 16;

    // Expected control bundles: {stall, flush, PC_sel, predict_taken, id_ex_bubble, id_pred, halt}
    localparam logic [6:0] E_NONE  = 7'b0000000;
    localparam logic [6:0] E_LU    = 7'b1000100;
    localparam logic [6:0] E_PRED  = 7'b0101010;
    localparam logic [6:0] E_MP    = 7'b0110100;
    localparam logic [6:0] E_REDIR = 7'b0100100;
    localparam logic [6:0] E_DRAIN = 7'b1000000;
    localparam logic [6:0] E_HALT  = 7'b0000001;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_is_branch, id_is_halt, id_use_rs1, id_use_rs2;
    logic [PC_W-1:0] id_pc, id_target, ex_pc, ex_target;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic ex_valid, ex_is_load, ex_is_branch, ex_taken, ex_predicted;
    logic stall, flush, PC_sel, predict_taken, id_ex_bubble, id_pred, halt;
    logic [PC_W-1:0] branch_target;
    logic [CNT_W-1:0] mispredict_cnt, branch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_hazard_ctrl #(
        .PC_W(PC_W), .REG_W(REG_W), .BHT_IDX_W(BHT_IDX_W),
        .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_is_branch(id_is_branch),
        .id_target(id_target), .id_is_halt(id_is_halt),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_predicted(ex_predicted),
        .ex_pc(ex_pc), .ex_target(ex_target),
        .stall(stall), .flush(flush), .PC_sel(PC_sel), .predict_taken(predict_taken),
        .branch_target(branch_target), .id_ex_bubble(id_ex_bubble), .id_pred(id_pred),
        .halt(halt), .mispredict_cnt(mispredict_cnt), .branch_cnt(branch_cnt)
    );

    typedef struct packed {
        logic             pre_rst;
        logic             id_valid;
        logic [PC_W-1:0]  id_pc;
        logic             id_is_branch;
        logic [PC_W-1:0]  id_target;
        logic             id_is_halt;
        logic [REG_W-1:0] id_rs1;
        logic [REG_W-1:0] id_rs2;
        logic             id_use_rs1;
        logic             id_use_rs2;
        logic             ex_valid;
        logic             ex_is_load;
        logic [REG_W-1:0] ex_rd;
        logic             ex_is_branch;
        logic             ex_taken;
        logic             ex_predicted;
        logic [PC_W-1:0]  ex_pc;
        logic [PC_W-1:0]  ex_target;
        logic [6:0]       exp_o;
        logic [PC_W-1:0]  exp_tgt;
    } vec_t;

    vec_t  vecs[$];
    string names[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {stall, flush, PC_sel, predict_taken, id_ex_bubble, id_pred, halt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.id_valid; id_pc = t.id_pc; id_is_branch = t.id_is_branch;
        id_target = t.id_target; id_is_halt = t.id_is_halt;
        id_rs1 = t.id_rs1; id_rs2 = t.id_rs2; id_use_rs1 = t.id_use_rs1; id_use_rs2 = t.id_use_rs2;
        ex_valid = t.ex_valid; ex_is_load = t.ex_is_load; ex_rd = t.ex_rd;
        ex_is_branch = t.ex_is_branch; ex_taken = t.ex_taken; ex_predicted = t.ex_predicted;
        ex_pc = t.ex_pc; ex_target = t.ex_target;
    endtask

    function automatic vec_t mk(input logic [6:0] e, input logic [PC_W-1:0] tg);
        vec_t t = '0;
        t.exp_o = e;
        t.exp_tgt = tg;
        return t;
    endfunction

    function automatic vec_t ex_br(input vec_t t0, input logic [PC_W-1:0] pc, input logic tk,
                                   input logic pr, input logic [PC_W-1:0] tg);
        vec_t t = t0;
        t.ex_valid = 1'b1; t.ex_is_branch = 1'b1; t.ex_taken = tk;
        t.ex_predicted = pr; t.ex_pc = pc; t.ex_target = tg;
        return t;
    endfunction

    function automatic vec_t id_br(input vec_t t0, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tg);
        vec_t t = t0;
        t.id_valid = 1'b1; t.id_is_branch = 1'b1; t.id_pc = pc; t.id_target = tg;
        return t;
    endfunction

    function automatic vec_t id_hlt(input vec_t t0);
        vec_t t = t0;
        t.id_valid = 1'b1; t.id_is_halt = 1'b1;
        return t;
    endfunction

    function automatic vec_t with_rst(input vec_t t0);
        vec_t t = t0;
        t.pre_rst = 1'b1;
        return t;
    endfunction

    task automatic add(input string n, input vec_t t);
        names.push_back(n);
        vecs.push_back(t);
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i]);
            if (vecs[i].pre_rst) begin
                reset = 1'b1;
                #1;
                check({names[i], "_in_reset"}, {outs(), branch_target}, '0);
                reset = 1'b0;
            end
            #2;
            check(names[i], {outs(), branch_target}, {vecs[i].exp_o, vecs[i].exp_tgt});
            tick();
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_bht[2**BHT_IDX_W];
    int m_redir, m_drain, m_halted, m_mp, m_br;

    task automatic model_reset();
        foreach (m_bht[i]) m_bht[i] = 1;
        m_redir = 0; m_drain = 0; m_halted = 0; m_mp = 0; m_br = 0;
    endtask

    task automatic model_cycle(output logic [14:0] e_out, output logic [31:0] e_cnt);
        bit mp, lu, hd, pb;
        bit s, f, ps, pt, bb, ip;
        int tg, idx;
        mp = ex_valid && ex_is_branch && (ex_taken != ex_predicted);
        lu = id_valid && ex_valid && ex_is_load &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        hd = id_valid && id_is_halt;
        pb = m_bht[int'(id_pc) % (2**BHT_IDX_W)] >= 2;
        {s, f, ps, pt, bb} = '0;
        tg = 0;
        ip = id_is_branch && pb;
        if (m_halted != 0) begin
        end else if (mp) begin
            ps = 1; f = 1; bb = 1;
            tg = ex_taken ? int'(ex_target) : (int'(ex_pc) + 1) % 256;
        end else if (m_redir != 0) begin
            f = 1; bb = 1;
        end else if (m_drain > 0) begin
            s = 1;
        end else if (lu) begin
            s = 1; bb = 1;
        end else if (!hd && id_valid && id_is_branch && pb) begin
            pt = 1; f = 1; tg = int'(id_target);
        end
        e_out = {s, f, ps, pt, bb, ip, (m_halted != 0), 8'(tg)};
        e_cnt = {16'(m_mp), 16'(m_br)};
        // state advance at the coming clock edge
        if (ex_valid && ex_is_branch) begin
            idx = int'(ex_pc) % (2**BHT_IDX_W);
            m_bht[idx] = ex_taken ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                                  : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
            if (m_br < 65535) m_br++;
        end
        if (mp && m_mp < 65535) m_mp++;
        if (m_halted == 0) begin
            if (mp) begin
                m_redir = 1; m_drain = 0;
            end else if (m_redir != 0) begin
                m_redir = 0;
            end else if (m_drain > 0) begin
                m_drain--;
                if (m_drain == 0) m_halted = 1;
            end else if (!lu && hd) begin
                m_drain = DRAIN_CYC;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        logic [14:0] e_out;
        logic [31:0] e_cnt;
        logic [3:0]  opc;

        // Reset with active-looking inputs: outputs must stay quiet
        reset = 1'b1;
        t = ex_br(id_br(mk(E_NONE, 8'h00), 8'h04, 8'h20), 8'h10, 1'b1, 1'b0, 8'h55);
        drive(t);
        #2;
        check("reset_outs", {outs(), branch_target}, '0);
        check("reset_cnts", {mispredict_cnt, branch_cnt}, '0);
        tick();
        tick();
        reset = 1'b0;

        // ---------------- directed vector table ----------------
        add("idle", mk(E_NONE, 8'h00));
        add("bht_init_no_pred", id_br(mk(E_NONE, 8'h00), 8'h10, 8'h30));
        t = mk(E_LU, 8'h00);
        t.ex_valid = 1; t.ex_is_load = 1; t.ex_rd = 4'd3;
        t.id_valid = 1; t.id_rs1 = 4'd5; t.id_use_rs1 = 1; t.id_rs2 = 4'd3; t.id_use_rs2 = 1;
        add("load_use", t);
        t.ex_is_load = 0; t.exp_o = E_NONE;
        add("load_use_release", t);
        add("br_taken_1", ex_br(mk(E_NONE, 8'h00), 8'h04, 1'b1, 1'b1, 8'h20));
        add("br_taken_2", ex_br(mk(E_NONE, 8'h00), 8'h04, 1'b1, 1'b1, 8'h20));
        add("predict_taken", id_br(mk(E_PRED, 8'h20), 8'h04, 8'h20));
        add("mispredict_wrap", ex_br(mk(E_MP, 8'h00), 8'hFF, 1'b0, 1'b1, 8'h33));
        add("redir_flush", mk(E_REDIR, 8'h00));
        add("redir_done", mk(E_NONE, 8'h00));
        // 10
        t = id_hlt(ex_br(mk(E_MP, 8'h40), 8'h30, 1'b1, 1'b0, 8'h40));
        t.ex_is_load = 1; t.ex_rd = 4'd3; t.id_rs1 = 4'd3; t.id_use_rs1 = 1;
        add("mp_over_hazard", t);
        add("mp_hazard_redir", mk(E_REDIR, 8'h00));
        add("mp_hazard_run", mk(E_NONE, 8'h00));
        add("halt_decode", id_hlt(mk(E_NONE, 8'h00)));
        add("drain_1", mk(E_DRAIN, 8'h00));
        add("drain_2", mk(E_DRAIN, 8'h00));
        add("drain_3", mk(E_DRAIN, 8'h00));
        add("halted", mk(E_HALT, 8'h00));
        add("halted_ignores_mp", ex_br(mk(E_HALT, 8'h00), 8'h50, 1'b1, 1'b0, 8'h60));
        add("reset_exits_halt", with_rst(mk(E_NONE, 8'h00)));
        // 20
        add("halt_decode_2", id_hlt(mk(E_NONE, 8'h00)));
        add("drain2_c1", mk(E_DRAIN, 8'h00));
        add("drain2_c2_mp", ex_br(mk(E_MP, 8'h60), 8'h50, 1'b1, 1'b0, 8'h60));
        add("abort_redir", mk(E_REDIR, 8'h00));
        add("abort_run_1", mk(E_NONE, 8'h00));
        add("abort_run_2", mk(E_NONE, 8'h00));
        add("abort_run_3", mk(E_NONE, 8'h00));
        add("halt_decode_3", id_hlt(mk(E_NONE, 8'h00)));
        add("drain3_c1", mk(E_DRAIN, 8'h00));
        add("reset_mid_drain", with_rst(mk(E_NONE, 8'h00)));
        // 30
        add("after_drain_reset", mk(E_NONE, 8'h00));
        add("mp_before_reset", ex_br(mk(E_MP, 8'h71), 8'h70, 1'b0, 1'b1, 8'h11));
        add("reset_mid_redir", with_rst(mk(E_NONE, 8'h00)));
        add("after_redir_reset", mk(E_NONE, 8'h00));

        run_table(0, 9);
        check("cnt_mispredict", 64'(mispredict_cnt), 64'd1);
        check("cnt_branch", 64'(branch_cnt), 64'd3);
        run_table(10, vecs.size() - 1);

        // ---------------- randomized traffic vs model ----------------
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
                model_reset();
            end
            id_valid     = ($urandom_range(0, 3) != 0);
            id_pc        = 8'($urandom_range(0, 255));
            id_is_branch = ($urandom_range(0, 9) < 3);
            id_target    = 8'($urandom_range(0, 255));
            opc          = 4'($urandom_range(0, 15));
            id_is_halt   = !id_is_branch && (opc == OPC_HALT) && ($urandom_range(0, 3) == 0);
            id_rs1       = 4'($urandom_range(0, 3));
            id_rs2       = 4'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            ex_valid     = ($urandom_range(0, 4) != 0);
            ex_is_load   = ($urandom_range(0, 9) < 3);
            ex_rd        = 4'($urandom_range(0, 3));
            ex_is_branch = ($urandom_range(0, 9) < 4);
            ex_taken     = 1'($urandom_range(0, 1));
            ex_predicted = ($urandom_range(0, 3) == 0) ? !ex_taken : ex_taken;
            ex_pc        = 8'($urandom_range(0, 255));
            ex_target    = 8'($urandom_range(0, 255));
            #2;
            model_cycle(e_out, e_cnt);
            check("rand_outs", {outs(), branch_target}, 64'(e_out));
            check("rand_cnts", {mispredict_cnt, branch_cnt}, 64'(e_cnt));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_hazard_ctrl
`default_nettype wire
